// File: rtl/control_cmd_queue.sv
// Multi-channel command queue: per-channel pending slots, fixed-priority arbiter,
// FIFO with valid/ready pop, flush, saturating drop accounting and optional coalescing.
module control_cmd_queue #(
  parameter int NCH          = 4,
  parameter int CMD_W        = 4,
  parameter int DEPTH        = 8,
  parameter int COALESCE_CMD = 0,
  parameter int DROP_W       = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic [NCH-1:0]               in_valid,
  input  logic [NCH*CMD_W-1:0]         in_cmd,
  output logic                         out_valid,
  output logic [CMD_W-1:0]             out_cmd,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic [DROP_W-1:0]            drop_cnt
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0]    FULL = CW'(DEPTH);
  localparam logic [PW-1:0]    LAST = PW'(DEPTH-1);
  localparam logic [CMD_W-1:0] COAL = CMD_W'(COALESCE_CMD);

  logic [CMD_W-1:0]  r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [NCH-1:0]    r_pend_v;
  logic [CMD_W-1:0]  r_pend_c [NCH];
  logic [CMD_W-1:0]  r_last;
  logic              r_overflow;
  logic [DROP_W-1:0] r_drop;

  logic              w_pop, w_can_write, w_gany, w_coal, w_push, w_any_drop;
  logic [NCH-1:0]    w_grant, w_strobe;
  logic [CMD_W-1:0]  w_gcmd;
  logic [CW-1:0]     w_remain;
  logic [DROP_W-1:0] w_drop_next;

  assign w_pop       = (r_count != '0) && out_ready;
  assign w_can_write = (r_count != FULL) || w_pop;
  assign w_remain    = r_count - CW'(w_pop);

  always_comb begin
    w_gany  = 1'b0;
    w_grant = '0;
    w_gcmd  = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (!w_gany && r_pend_v[i] && w_can_write) begin
        w_gany     = 1'b1;
        w_grant[i] = 1'b1;
        w_gcmd     = r_pend_c[i];
      end
    end
  end

  // r_last is the FIFO tail whenever w_remain is non-zero, so a stale value after flush is harmless
  assign w_coal = (COALESCE_CMD != 0) && w_gany && (w_gcmd == COAL) &&
                  (r_last == COAL) && (w_remain != '0);
  assign w_push = w_gany && !w_coal;

  always_comb begin
    w_strobe    = '0;
    w_any_drop  = 1'b0;
    w_drop_next = r_drop;
    for (int unsigned i = 0; i < NCH; i++) begin
      w_strobe[i] = in_valid[i] && (in_cmd[i*CMD_W +: CMD_W] != '0);
      if (w_strobe[i] && r_pend_v[i] && !w_grant[i]) begin
        w_any_drop = 1'b1;
        if (w_drop_next != '1) w_drop_next = w_drop_next + DROP_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && !flush && w_push) r_mem[r_wr_ptr] <= w_gcmd;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_pend_v   <= '0;
      r_last     <= '0;
      r_overflow <= 1'b0;
      r_drop     <= '0;
      for (int unsigned i = 0; i < NCH; i++) r_pend_c[i] <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_pend_v <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + PW'(1);
        r_last   <= w_gcmd;
      end
      if (w_pop) r_rd_ptr <= (r_rd_ptr == LAST) ? '0 : r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      for (int unsigned i = 0; i < NCH; i++) begin
        if (w_strobe[i]) begin
          r_pend_v[i] <= 1'b1;
          r_pend_c[i] <= in_cmd[i*CMD_W +: CMD_W];
        end else if (w_grant[i]) begin
          r_pend_v[i] <= 1'b0;
        end
      end
      if (w_any_drop) r_overflow <= 1'b1;
      r_drop <= w_drop_next;
    end
  end

  assign out_valid = (r_count != '0);
  assign out_cmd   = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign drop_cnt  = r_drop;
endmodule

// File: tb/tb_control_cmd_queue.sv
// Bench for control_cmd_queue: queue-based reference model checked every cycle,
// plus literal expectations from hand-worked scenarios.
module tb_control_cmd_queue;
  localparam int NCH = 4, CMD_W = 4, DEPTH = 8, COAL = 2, DROP_W = 2;
  localparam int CW = $clog2(DEPTH+1);
  localparam int DMAX = (1 << DROP_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset_n, flush, out_ready, out_valid, overflow;
  logic [NCH-1:0]       in_valid;
  logic [NCH*CMD_W-1:0] in_cmd;
  logic [CMD_W-1:0]     out_cmd;
  logic [CW-1:0]        count;
  logic [DROP_W-1:0]    drop_cnt;

  control_cmd_queue #(.NCH(NCH), .CMD_W(CMD_W), .DEPTH(DEPTH),
                      .COALESCE_CMD(COAL), .DROP_W(DROP_W)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_cmd(in_cmd),
    .out_valid(out_valid), .out_cmd(out_cmd), .out_ready(out_ready),
    .count(count), .overflow(overflow), .drop_cnt(drop_cnt));

  int checks = 0;
  int errors = 0;

  int q[$];
  bit m_pv[NCH];
  int m_pc[NCH];
  bit m_ovf;
  int m_drop;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int  g;
    bit  pop, can, coal;
    int  c;
    if (!reset_n) begin
      q.delete();
      for (int i = 0; i < NCH; i++) begin m_pv[i] = 0; m_pc[i] = 0; end
      m_ovf  = 0;
      m_drop = 0;
    end else if (flush) begin
      q.delete();
      for (int i = 0; i < NCH; i++) m_pv[i] = 0;
    end else begin
      pop = (q.size() > 0) && out_ready;
      can = (q.size() < DEPTH) || pop;
      g = -1;
      if (can)
        for (int i = NCH-1; i >= 0; i--) if (m_pv[i]) g = i;
      coal = 0;
      if (g >= 0 && q.size() > 0)
        coal = (m_pc[g] == COAL) && (q[$] == COAL) && ((q.size() - int'(pop)) >= 1);
      if (pop) void'(q.pop_front());
      if (g >= 0 && !coal) q.push_back(m_pc[g]);
      for (int i = 0; i < NCH; i++) begin
        c = int'(in_cmd[i*CMD_W +: CMD_W]);
        if (in_valid[i] && c != 0) begin
          if (m_pv[i] && i != g) begin
            m_ovf = 1;
            if (m_drop < DMAX) m_drop++;
          end
          m_pv[i] = 1;
          m_pc[i] = c;
        end else if (i == g) begin
          m_pv[i] = 0;
        end
      end
    end
  endtask

  task automatic tick();
    int exp_head;
    @(posedge clk);
    model_step();
    #1;
    exp_head = (q.size() > 0) ? q[0] : 0;
    check("out_valid", 32'(out_valid), 32'(q.size() > 0));
    check("out_cmd",   32'(out_cmd),   32'(exp_head));
    check("count",     32'(count),     32'(q.size()));
    check("overflow",  32'(overflow),  32'(m_ovf));
    check("drop_cnt",  32'(drop_cnt),  32'(m_drop));
  endtask

  task automatic set_ch(input int ch, input int cmd);
    logic [CMD_W-1:0] v;
    v = CMD_W'(cmd);
    in_valid[ch] = 1'b1;
    in_cmd[ch*CMD_W +: CMD_W] = v;
  endtask

  task automatic idle();
    in_valid = '0;
    in_cmd   = '0;
  endtask

  task automatic do_reset();
    idle();
    flush   = 1'b0;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    idle();
    flush = 1'b0;
    out_ready = 1'b0;
    do_reset();
    check("reset_count", 32'(count), 0);
    check("reset_valid", 32'(out_valid), 0);
    check("reset_cmd", 32'(out_cmd), 0);
    check("reset_ovf", 32'(overflow), 0);
    check("reset_drop", 32'(drop_cnt), 0);

    // single source, 2-cycle latency, one-cycle visibility
    out_ready = 1'b1;
    set_ch(2, 5); tick(); idle();
    check("single_lat0", 32'(out_valid), 0);
    tick();
    check("single_valid", 32'(out_valid), 1);
    check("single_cmd", 32'(out_cmd), 5);
    tick();
    check("single_gone", 32'(out_valid), 0);
    check("single_count", 32'(count), 0);

    // priority order
    out_ready = 1'b0;
    set_ch(0, 3); set_ch(1, 4); set_ch(3, 6); tick(); idle();
    repeat (3) tick();
    check("prio_count", 32'(count), 3);
    check("prio_head", 32'(out_cmd), 3);
    check("prio_drop", 32'(drop_cnt), 0);
    out_ready = 1'b1;
    tick();
    check("prio_second", 32'(out_cmd), 4);
    repeat (2) tick();
    check("prio_drained", 32'(count), 0);

    // full / backpressure / overwrite / push-with-pop at full
    do_reset();
    out_ready = 1'b0;
    foreach (q[i]) ; // no-op keeps q untouched
    begin
      int fill[8] = '{1, 3, 4, 5, 6, 7, 8, 9};
      for (int k = 0; k < 8; k++) begin idle(); set_ch(0, fill[k]); tick(); end
    end
    idle(); tick();
    check("full_count", 32'(count), 8);
    set_ch(1, 10); tick(); idle(); tick();
    check("full_hold", 32'(count), 8);
    check("full_noovf", 32'(overflow), 0);
    set_ch(1, 7); tick(); idle();
    check("full_ovf", 32'(overflow), 1);
    check("full_drop", 32'(drop_cnt), 1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check("full_pushpop", 32'(count), 8);
    check("full_head", 32'(out_cmd), 3);
    out_ready = 1'b1;
    repeat (7) tick();
    check("full_tail", 32'(out_cmd), 7);
    tick();
    check("full_empty", 32'(count), 0);

    // coalescing of repeated code 2
    do_reset();
    out_ready = 1'b0;
    begin
      int seq[4] = '{2, 2, 9, 2};
      for (int k = 0; k < 4; k++) begin idle(); set_ch(3, seq[k]); tick(); end
    end
    idle(); repeat (2) tick();
    check("coal_count", 32'(count), 3);
    check("coal_head", 32'(out_cmd), 2);
    check("coal_drop", 32'(drop_cnt), 0);
    out_ready = 1'b1;
    tick();
    check("coal_mid", 32'(out_cmd), 9);
    repeat (3) tick();

    // flush with pending slots and a coincident strobe
    do_reset();
    out_ready = 1'b0;
    begin
      int fill5[5] = '{1, 3, 4, 5, 6};
      for (int k = 0; k < 5; k++) begin idle(); set_ch(0, fill5[k]); tick(); end
    end
    idle(); tick();
    check("flush_pre5", 32'(count), 5);
    set_ch(0, 9); set_ch(1, 10); tick(); idle();
    set_ch(1, 11); tick(); idle();
    set_ch(1, 7); set_ch(3, 8); tick(); idle();
    check("flush_pre7", 32'(count), 7);
    flush = 1'b1; set_ch(0, 12); tick(); idle(); flush = 1'b0;
    check("flush_count", 32'(count), 0);
    check("flush_valid", 32'(out_valid), 0);
    check("flush_cmd", 32'(out_cmd), 0);
    check("flush_ovf", 32'(overflow), 1);
    check("flush_drop", 32'(drop_cnt), 1);
    out_ready = 1'b1;
    repeat (3) tick();
    check("flush_nopend", 32'(count), 0);

    // stream across pointer wrap, then drop saturation
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin idle(); set_ch(0, (k % 13) + 3); tick(); end
    check("wrap_head", 32'(out_cmd), 8);
    check("wrap_count", 32'(count), 1);
    idle(); repeat (3) tick();
    check("wrap_empty", 32'(count), 0);
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin set_ch(0, 3); set_ch(1, 4); tick(); end
    idle();
    check("sat_drop", 32'(drop_cnt), 3);
    check("sat_ovf", 32'(overflow), 1);
    check("sat_count", 32'(count), 5);

    // reset mid-operation clears sticky state
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    check("midrst_count", 32'(count), 0);
    check("midrst_drop", 32'(drop_cnt), 0);
    check("midrst_ovf", 32'(overflow), 0);
    out_ready = 1'b1;
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/control_cmd_queue.md
Name: control_cmd_queue

Overview:
- Parametrised command queue between the input sources (debounced buttons, switch edges, UART decoder, gravity/bar timers) and the game state machine.
- Generalises the single-source queue to NCH independent input channels. Each channel has its own pending slot; channels are arbitrated by fixed priority.
- Adds a valid/ready consumer handshake, an explicit flush, overflow accounting, and optional coalescing of repeated gravity commands.

Parameters:
- NCH, 4, number of input channels; channel 0 has highest priority.
- CMD_W, 4, command code width; code 0 means NONE.
- DEPTH, 8, FIFO entries (>=2, any value; not restricted to powers of two).
- COALESCE_CMD, 0, command code to coalesce (e.g. DOWN); 0 disables coalescing.
- DROP_W, 8, width of the saturating drop counter.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous, active-low reset.
- flush  in  1  empties the FIFO and all pending slots (game over / restart).
- in_valid  in  NCH  per-channel command strobe.
- in_cmd  in  NCH*CMD_W  per-channel command; channel i occupies bits [i*CMD_W +: CMD_W].
- out_valid  out  1  FIFO non-empty.
- out_cmd  out  CMD_W  head command; 0 when empty.
- out_ready  in  1  consumer accepts the head (asserted while the game FSM is in WAIT).
- count  out  $clog2(DEPTH+1)  current FIFO occupancy.
- overflow  out  1  sticky; a command was lost.
- drop_cnt  out  DROP_W  number of lost commands, saturating.

Behaviour:
- Reset: FIFO empty, pointers 0, all pending slots empty. Outputs: out_valid=0, out_cmd=0, count=0, overflow=0, drop_cnt=0.
- Input stage:
  - A strobe on channel i with in_valid[i]=1 and in_cmd!=0 loads pend[i] at the clock edge.
  - in_valid with cmd==0 is ignored.
  - If pend[i] is already occupied and not being granted this cycle, the new command overwrites it (latest wins). overflow is set and drop_cnt increments.
- Arbiter: each cycle, grant the lowest-index occupied pending slot, provided a write is possible. A write is possible when count<DEPTH, or when count==DEPTH and a pop happens in the same cycle.
  - A granted slot clears at the edge, unless the same channel strobes again that cycle; in that case the slot reloads with the new command and no drop is counted.
  - Ungranted slots hold (backpressure; no loss).
  - At most one push per cycle.
- Latency: in_valid at edge t → pending at t → FIFO write at t+1 → out_valid high after edge t+1. Minimum in-to-out is 2 cycles.
- Pop: out_valid && out_ready pops the head at the edge. out_cmd is the registered head entry; it is never combinationally dependent on inputs.
- Simultaneous push and pop: count unchanged. This holds at full and at count==1.
- Pointer wrap: pointers wrap DEPTH-1 → 0.
- Coalescing: applies when COALESCE_CMD!=0, the granted command == COALESCE_CMD, the most recently written entry == COALESCE_CMD, and (count − pop) ≥ 1.
  - The granted slot is cleared with no write.
  - This is not counted as a drop.
  - If the tail entry is being popped and count==1, the command is written normally.
- Flush: has priority over everything in its cycle.
  - FIFO is emptied (count=0, pointers 0) and all pending slots are cleared.
  - Strobes in the flush cycle are discarded and not counted.
  - overflow and drop_cnt are retained; only reset clears them.
- drop_cnt saturates at 2^DROP_W−1. overflow stays set until reset.
- Reset mid-operation: all state returns to reset values on the next edge, regardless of handshake state.

Test Plan:
- Single source: ch2 strobes cmd 5 at cycle 0, out_ready=1 → out_valid high from cycle 2 with out_cmd=5 for exactly 1 cycle; count returns to 0.
- Priority: ch0=3, ch1=4, ch3=6 strobed in the same cycle, out_ready=0 → FIFO order 3,4,6; count=3 after 3 grant cycles; no drops.
- Full/backpressure, DEPTH=8: push 8 commands with out_ready=0 → count=8. A 9th strobe on ch1 holds in pend. A second ch1 strobe (cmd 7) overwrites it → overflow=1, drop_cnt=1. Pulse out_ready once → the 7 enters the FIFO on the same edge as the pop; count stays 8.
- Coalesce, COALESCE_CMD=2: with out_ready=0, ch3 strobes 2, 2, 9, 2 → FIFO holds 2, 9, 2 (count=3); drop_cnt=0.
- Flush: FIFO count=5 plus two pending slots, then flush coincident with a ch0 strobe → next cycle count=0, out_valid=0, out_cmd=0, all pending slots empty; overflow and drop_cnt unchanged.
- Wrap/saturation, DROP_W=2: stream 20 push/pop pairs → order preserved across the pointer wrap. Force 5 overwrites → drop_cnt=3.
